lsu: RTL and testbench
======================

LSU -- requirements
Module: lsu

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, the maximum cycles to wait for mem_ready before aborting (range 1..255).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1; one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port req_valid, input, 1, a load/store request from the core.
REQ-005 SHALL have port req_store, input, 1, 1=store, 0=load.
REQ-006 SHALL have port req_funct3, input, 3, RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW).
REQ-007 SHALL have port req_addr, input, 32, the byte address (the ALU result).
REQ-008 SHALL have port req_wdata, input, 32, store data (rs2).
REQ-009 SHALL have port busy, output, 1, high whenever state is not IDLE; the core stalls on it.
REQ-010 SHALL have port done, output, 1, a one-cycle completion pulse.
REQ-011 SHALL have port rdata, output, 32, extended load data, valid while done=1.
REQ-012 SHALL have port err, output, 2, valid while done=1: 00 ok, 01 misaligned, 10 illegal funct3, 11 bus timeout.
REQ-013 SHALL have port mem_req, output, 1, the memory request.
REQ-014 SHALL have port mem_we, output, 1, memory write enable.
REQ-015 SHALL have port mem_addr, output, 32, the word address, {req_addr[31:2],2'b00}.
REQ-016 SHALL have port mem_wdata, output, 32, lane-replicated store data.
REQ-017 SHALL have port mem_be, output, 4, byte enables.
REQ-018 SHALL have port mem_ready, input, 1, memory completion.
REQ-019 SHALL have port mem_rdata, input, 32, memory read word, valid when mem_ready=1.

Function
REQ-020 SHALL implement FSM IDLE -> ACCESS -> DONE -> IDLE, with the error path IDLE -> DONE.
REQ-021 IDLE: req_valid=1 SHALL accept the request and register store flag, funct3, addr and wdata; go to ACCESS, or to DONE if misaligned or illegal.
REQ-022 Misaligned SHALL mean: halfword with addr[0]=1, or word with addr[1:0]!=0; then err=01, no mem_req, no memory side effect.
REQ-023 Illegal SHALL mean: load funct3 in {3,6,7} or store funct3 >= 3; then err=10; illegal takes priority over misaligned.
REQ-024 ACCESS: mem_req=1 and address, data, be and we SHALL be held stable until mem_ready=1; then capture mem_rdata and go to DONE.
REQ-025 ACCESS: an 8-bit wait counter SHALL clear on entry and increment each cycle without mem_ready; on reaching TIMEOUT_CYCLES, drop mem_req next cycle, go to DONE with err=11.
REQ-026 mem_ready in the same cycle the counter reaches TIMEOUT_CYCLES SHALL count as success.
REQ-027 DONE: done=1 for exactly one cycle, then IDLE; req_valid SHALL be ignored while busy=1.
REQ-028 Minimum latency SHALL be: accept at edge N, mem_req high in cycle N+1, mem_ready in N+1 gives done in N+2; the error path gives done in N+1.
REQ-029 Store lanes SHALL be: SB wdata[7:0] replicated x4, be=0001<<addr[1:0]; SH {2{wdata[15:0]}}, be=0011 or 1100 by addr[1]; SW be=1111.
REQ-030 Loads SHALL drive mem_we=0 and mem_be as for the same-width store.
REQ-031 Load extension SHALL be: LB/LH sign-extend and LBU/LHU zero-extend the lane selected by addr[1:0]; LW passes the word.
REQ-032 rdata SHALL be 0 for stores and on any err!=00.
REQ-033 mem_we SHALL be 0 and mem_wdata/mem_be SHALL be 0 whenever mem_req=0.

Reset
REQ-034 rst_n low SHALL asynchronously force IDLE, counter=0, and busy, done, mem_req, mem_we, mem_be, rdata, err, mem_addr and mem_wdata all 0.
REQ-035 Reset during ACCESS SHALL drop mem_req immediately, discard the transaction and produce no done pulse.
REQ-036 The first request SHALL be accepted on the first rising edge after rst_n deasserts.

Structure
REQ-037 Package lsu_pkg SHALL hold the funct3 constants, the state enum and the err code constants.
REQ-038 Combinational lane steering and extension SHALL live in the sub-module lsu_align; lsu holds the FSM, registers and counter.

Verification
REQ-039 Test LW: addr=0x100, mem_ready in the first ACCESS cycle, mem_rdata=0xDEADBEEF -> done two cycles after accept, rdata=0xDEADBEEF, err=00.
REQ-040 Test LB/LBU: addr=0x103, mem_rdata=0x80FF_FF00 -> LB rdata=0xFFFFFF80, LBU rdata=0x00000080.
REQ-041 Test SH: addr=0x202, wdata=0x1234ABCD -> mem_be=1100, mem_wdata=0xABCDABCD, mem_we=1, mem_addr=0x200.
REQ-042 Test misaligned LW: addr=0x101 -> no mem_req, done the next cycle, err=01.
REQ-043 Test timeout: TIMEOUT_CYCLES=4, mem_ready held low -> mem_req high for 4 cycles, then done with err=11.
REQ-044 Test reset: rst_n pulled low in the second ACCESS cycle -> mem_req=0 and busy=0 asynchronously, no done pulse; a request after release completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: RV32I funct3 values, FSM states,
// completion error codes and the request pre-check done at accept time.
package lsu_pkg;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_DONE   = 2'd2
   } state_e;

   localparam logic [2:0] F3_LB  = 3'd0;
   localparam logic [2:0] F3_LH  = 3'd1;
   localparam logic [2:0] F3_LW  = 3'd2;
   localparam logic [2:0] F3_LBU = 3'd4;
   localparam logic [2:0] F3_LHU = 3'd5;
   localparam logic [2:0] F3_SB  = 3'd0;
   localparam logic [2:0] F3_SH  = 3'd1;
   localparam logic [2:0] F3_SW  = 3'd2;

   localparam logic [1:0] ERR_OK       = 2'b00;
   localparam logic [1:0] ERR_MISALIGN = 2'b01;
   localparam logic [1:0] ERR_ILLEGAL  = 2'b10;
   localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

   // Illegal encodings win over misalignment.
   function automatic logic [1:0] decode_err(input logic       store,
                                             input logic [2:0] f3,
                                             input logic [1:0] addr_lo);
      logic illegal;
      logic misaligned;
      illegal    = store ? (f3 >= 3'd3) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
      misaligned = (f3[1:0] == 2'b01 && addr_lo[0]) || (f3[1:0] == 2'b10 && addr_lo != 2'b00);
      if (illegal)
         return ERR_ILLEGAL;
      else if (misaligned)
         return ERR_MISALIGN;
      else
         return ERR_OK;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for stores (replicated data + byte enables) and
// lane selection with sign/zero extension for loads.
module lsu_align
   import lsu_pkg::*;
(
   input  logic        store_i,
   input  logic [2:0]  funct3_i,
   input  logic [1:0]  addr_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] mem_rdata_i,
   output logic [31:0] wdata_o,
   output logic [3:0]  be_o,
   output logic [31:0] rdata_o
);

   logic [7:0]  lane [4];
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign lane[gi] = mem_rdata_i[8*gi +: 8];
   end

   assign byte_sel = lane[addr_i];
   assign half_sel = addr_i[1] ? {lane[3], lane[2]} : {lane[1], lane[0]};

   // Loads use the same enables as a store of equal width.
   always_comb begin
      case (funct3_i[1:0])
         2'b00: begin
            wdata_o = {4{wdata_i[7:0]}};
            be_o    = 4'b0001 << addr_i;
         end
         2'b01: begin
            wdata_o = {2{wdata_i[15:0]}};
            be_o    = addr_i[1] ? 4'b1100 : 4'b0011;
         end
         default: begin
            wdata_o = wdata_i;
            be_o    = 4'b1111;
         end
      endcase
   end

   always_comb begin
      rdata_o = '0;
      if (!store_i) begin
         case (funct3_i)
            F3_LB:   rdata_o = {{24{byte_sel[7]}}, byte_sel};
            F3_LH:   rdata_o = {{16{half_sel[15]}}, half_sel};
            F3_LW:   rdata_o = mem_rdata_i;
            F3_LBU:  rdata_o = {24'h0, byte_sel};
            F3_LHU:  rdata_o = {16'h0, half_sel};
            default: rdata_o = '0;
         endcase
      end
   end

endmodule

// File: rtl/lsu.sv
// Load/store unit: accepts one core request, runs a single memory access with
// a bounded wait, and reports the result with a one-cycle done pulse.
module lsu
   import lsu_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   input  logic        req_store,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        busy,
   output logic        done,
   output logic [31:0] rdata,
   output logic [1:0]  err,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_be,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata
);

   localparam logic [8:0] TO_LIMIT = 9'(TIMEOUT_CYCLES);

   state_e      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [8:0]  cnt_inc;
   logic        store_q, store_d;
   logic [2:0]  funct3_q, funct3_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [1:0]  err_q, err_d;
   logic [31:0] rdata_q, rdata_d;
   logic [31:0] lane_wdata;
   logic [3:0]  lane_be;
   logic [31:0] lane_rdata;

   lsu_align u_align (
      .store_i     (store_q),
      .funct3_i    (funct3_q),
      .addr_i      (addr_q[1:0]),
      .wdata_i     (wdata_q),
      .mem_rdata_i (mem_rdata),
      .wdata_o     (lane_wdata),
      .be_o        (lane_be),
      .rdata_o     (lane_rdata)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         store_q  <= 1'b0;
         funct3_q <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         err_q    <= ERR_OK;
         rdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         store_q  <= store_d;
         funct3_q <= funct3_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         err_q    <= err_d;
         rdata_q  <= rdata_d;
      end
   end

   assign cnt_inc = {1'b0, cnt_q} + 9'd1;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      store_d  = store_q;
      funct3_d = funct3_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      err_d    = err_q;
      rdata_d  = rdata_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               store_d  = req_store;
               funct3_d = req_funct3;
               addr_d   = req_addr;
               wdata_d  = req_wdata;
               cnt_d    = '0;
               rdata_d  = '0;
               err_d    = decode_err(req_store, req_funct3, req_addr[1:0]);
               state_d  = (err_d == ERR_OK) ? S_ACCESS : S_DONE;
            end
         end
         S_ACCESS: begin
            // A ready arriving on the final allowed cycle still completes.
            if (mem_ready) begin
               rdata_d = lane_rdata;
               state_d = S_DONE;
            end else if (cnt_inc == TO_LIMIT) begin
               err_d   = ERR_TIMEOUT;
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_inc[7:0];
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      busy      = (state_q != S_IDLE);
      done      = (state_q == S_DONE);
      mem_req   = (state_q == S_ACCESS);
      mem_we    = mem_req & store_q;
      mem_addr  = mem_req ? {addr_q[31:2], 2'b00} : '0;
      mem_wdata = mem_req ? lane_wdata : '0;
      mem_be    = mem_req ? lane_be : '0;
      rdata     = done ? rdata_q : '0;
      err       = done ? err_q : ERR_OK;
   end

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: a table of single transactions with hand-computed
// results, plus sequences for reset release, busy masking and mid-access reset.
module tb_lsu;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid = 1'b0;
   logic        req_store = 1'b0;
   logic [2:0]  req_funct3 = 3'd0;
   logic [31:0] req_addr = 32'h0;
   logic [31:0] req_wdata = 32'h0;
   logic        busy;
   logic        done;
   logic [31:0] rdata;
   logic [1:0]  err;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_ready = 1'b0;
   logic [31:0] mem_rdata = 32'h0;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        store;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] mrd;
      int          dly;
      logic [1:0]  err;
      logic [31:0] rdata;
      logic [3:0]  be;
      logic [31:0] mwd;
      int          lat;
      int          reqs;
   } vec_t;

   vec_t vecs [17];

   lsu #(.TIMEOUT_CYCLES(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_store  (req_store),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .busy       (busy),
      .done       (done),
      .rdata      (rdata),
      .err        (err),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_be     (mem_be),
      .mem_ready  (mem_ready),
      .mem_rdata  (mem_rdata)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      int cyc;
      int acc;
      req_valid  = 1'b1;
      req_store  = v.store;
      req_funct3 = v.f3;
      req_addr   = v.addr;
      req_wdata  = v.wdata;
      @(posedge clk); #1;
      req_valid = 1'b0;
      req_addr  = 32'hFFFF_FFFF;
      req_wdata = 32'h0;
      cyc = 0;
      acc = 0;
      while (done !== 1'b1 && cyc < 12) begin
         if (mem_req === 1'b1) begin
            chk("lanes", {mem_we, mem_be, mem_addr}, {v.store, v.be, v.addr[31:2], 2'b00});
            if (v.store) chk("wdata", mem_wdata, v.mwd);
            mem_ready = (acc == v.dly);
            mem_rdata = v.mrd;
            acc++;
         end
         @(posedge clk); #1;
         mem_ready = 1'b0;
         mem_rdata = 32'h0;
         cyc++;
      end
      chk("latency", cyc, v.lat);
      chk("req_cycles", acc, v.reqs);
      chk("err", err, v.err);
      chk("rdata", rdata, v.rdata);
      chk("bus_idle", {mem_req, mem_we, mem_be, mem_wdata}, 0);
      $display("vec %0d: store=%0d f3=%0d addr=%h err=%b rdata=%h latency=%0d",
               idx, v.store, v.f3, v.addr, err, rdata, cyc);
      @(posedge clk); #1;
      chk("pulse_end", {done, busy}, 0);
   endtask

   initial begin
      logic seen;

      vecs[0]  = '{1'b0, 3'd2, 32'h100, 32'h0,        32'hDEADBEEF, 0,  2'b00, 32'hDEADBEEF, 4'b1111, 32'h0,        1, 1};
      vecs[1]  = '{1'b0, 3'd0, 32'h103, 32'h0,        32'h80FFFF00, 0,  2'b00, 32'hFFFFFF80, 4'b1000, 32'h0,        1, 1};
      vecs[2]  = '{1'b0, 3'd4, 32'h103, 32'h0,        32'h80FFFF00, 0,  2'b00, 32'h00000080, 4'b1000, 32'h0,        1, 1};
      vecs[3]  = '{1'b0, 3'd1, 32'h102, 32'h0,        32'h80011234, 2,  2'b00, 32'hFFFF8001, 4'b1100, 32'h0,        3, 3};
      vecs[4]  = '{1'b0, 3'd5, 32'h100, 32'h0,        32'h8001F234, 1,  2'b00, 32'h0000F234, 4'b0011, 32'h0,        2, 2};
      vecs[5]  = '{1'b0, 3'd0, 32'h101, 32'h0,        32'h00007F00, 0,  2'b00, 32'h0000007F, 4'b0010, 32'h0,        1, 1};
      vecs[6]  = '{1'b1, 3'd1, 32'h202, 32'h1234ABCD, 32'hFFFFFFFF, 0,  2'b00, 32'h0,        4'b1100, 32'hABCDABCD, 1, 1};
      vecs[7]  = '{1'b1, 3'd0, 32'h301, 32'h000000A5, 32'hFFFFFFFF, 1,  2'b00, 32'h0,        4'b0010, 32'hA5A5A5A5, 2, 2};
      vecs[8]  = '{1'b1, 3'd2, 32'h404, 32'hCAFEF00D, 32'h0,        0,  2'b00, 32'h0,        4'b1111, 32'hCAFEF00D, 1, 1};
      vecs[9]  = '{1'b0, 3'd2, 32'h101, 32'h0,        32'hFFFFFFFF, 0,  2'b01, 32'h0,        4'b0000, 32'h0,        0, 0};
      vecs[10] = '{1'b0, 3'd1, 32'h103, 32'h0,        32'hFFFFFFFF, 0,  2'b01, 32'h0,        4'b0000, 32'h0,        0, 0};
      vecs[11] = '{1'b1, 3'd2, 32'h102, 32'h11111111, 32'h0,        0,  2'b01, 32'h0,        4'b0000, 32'h0,        0, 0};
      vecs[12] = '{1'b0, 3'd6, 32'h101, 32'h0,        32'hFFFFFFFF, 0,  2'b10, 32'h0,        4'b0000, 32'h0,        0, 0};
      vecs[13] = '{1'b1, 3'd4, 32'h100, 32'h22222222, 32'h0,        0,  2'b10, 32'h0,        4'b0000, 32'h0,        0, 0};
      vecs[14] = '{1'b0, 3'd2, 32'h500, 32'h0,        32'h12345678, 99, 2'b11, 32'h0,        4'b1111, 32'h0,        4, 4};
      vecs[15] = '{1'b0, 3'd2, 32'h504, 32'h0,        32'h13572468, 3,  2'b00, 32'h13572468, 4'b1111, 32'h0,        4, 4};
      vecs[16] = '{1'b1, 3'd0, 32'h603, 32'h0000005A, 32'h0,        3,  2'b00, 32'h0,        4'b1000, 32'h5A5A5A5A, 4, 4};

      // Reset state
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #10;
      chk("reset_state", {busy, done, mem_req, mem_we, mem_be, err, rdata}, 0);
      chk("reset_bus", {mem_addr, mem_wdata}, 0);

      // First request accepted on the first edge after reset release
      @(posedge clk); #1;
      rst_n      = 1'b1;
      req_valid  = 1'b1;
      req_store  = 1'b0;
      req_funct3 = 3'd2;
      req_addr   = 32'h600;
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk("first_accept", {busy, mem_req, mem_addr}, {1'b1, 1'b1, 32'h600});
      mem_ready = 1'b1;
      mem_rdata = 32'h600DCAFE;
      @(posedge clk); #1;
      mem_ready = 1'b0;
      chk("first_done", {done, err, rdata}, {1'b1, 2'b00, 32'h600DCAFE});
      $display("first request after reset: done=%0d rdata=%h", done, rdata);
      @(posedge clk); #1;

      for (int i = 0; i < 17; i++) run_vec(i, vecs[i]);

      // Requests presented while busy must be ignored
      req_valid  = 1'b1;
      req_store  = 1'b0;
      req_funct3 = 3'd2;
      req_addr   = 32'h700;
      @(posedge clk); #1;
      req_store  = 1'b1;
      req_funct3 = 3'd0;
      req_addr   = 32'h801;
      req_wdata  = 32'hFF;
      chk("busy_hold1", {busy, mem_req, mem_we, mem_addr}, {1'b1, 1'b1, 1'b0, 32'h700});
      @(posedge clk); #1;
      chk("busy_hold2", {busy, mem_req, mem_we, mem_addr, mem_be}, {1'b1, 1'b1, 1'b0, 32'h700, 4'b1111});
      mem_ready = 1'b1;
      mem_rdata = 32'h0BADF00D;
      @(posedge clk); #1;
      mem_ready = 1'b0;
      chk("busy_done", {done, err, rdata}, {1'b1, 2'b00, 32'h0BADF00D});
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk("busy_idle", {busy, done, mem_req}, 0);
      $display("busy masking: load 0x700 completed with rdata=%h", 32'h0BADF00D);
      @(posedge clk); #1;

      // Reset during the second ACCESS cycle
      req_valid  = 1'b1;
      req_store  = 1'b0;
      req_funct3 = 3'd2;
      req_addr   = 32'h800;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      chk("rst_pre", {busy, mem_req}, {1'b1, 1'b1});
      #2 rst_n = 1'b0;
      #1;
      chk("rst_async", {mem_req, busy, done}, 0);
      seen = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
         if (done === 1'b1) seen = 1'b1;
      end
      chk("rst_no_done", seen, 1'b0);
      $display("reset mid-access: mem_req=%0d busy=%0d", mem_req, busy);
      rst_n = 1'b1;
      @(posedge clk); #1;
      run_vec(100, vecs[0]);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
